// File: rtl/sysbus_mem_if_if.sv
// SysBus/controller/memory signal bundle for sysbus_mem_if; slave modport is the block itself,
// master modport is the controller plus memory side that drives requests, read data and MemReady.
interface sysbus_mem_if_if;
    logic        ReqRead;
    logic        ReqWrite;
    logic [15:0] SysBusIn;
    logic [15:0] DataIn;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic [15:0] MemRData;
    logic        MemRe;
    logic        MemWe;
    logic        MemReady;

    modport slave (
        input  ReqRead,
        input  ReqWrite,
        input  SysBusIn,
        input  MemRData,
        input  MemReady,
        output DataIn,
        output Busy,
        output Done,
        output Error,
        output MemAddr,
        output MemWData,
        output MemRe,
        output MemWe
    );

    modport master (
        output ReqRead,
        output ReqWrite,
        output SysBusIn,
        output MemRData,
        output MemReady,
        input  DataIn,
        input  Busy,
        input  Done,
        input  Error,
        input  MemAddr,
        input  MemWData,
        input  MemRe,
        input  MemWe
    );
endinterface

// File: rtl/sysbus_mem_if.sv
// Single-outstanding SysBus-to-memory access FSM (IDLE/ADDR/ACCESS/DONE); timeout logic under MEMIF_TIMEOUT_EN.
// Latency: request in cycle 0, ADDR 1, ACCESS from 2, Done at 3 + memory wait states.
// Backpressure: MemReady stretches ACCESS; requests outside IDLE are dropped, not queued.
module sysbus_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic           Clock,
    input  logic           nReset,
    sysbus_mem_if_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        is_rd;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        req;
    logic        timeout;
    logic        busy_c;
    logic        done_c;
    logic        re_c;
    logic        we_c;

    assign req = bus.ReqRead | bus.ReqWrite;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        re_c      = 1'b0;
        we_c      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                busy_c    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                busy_c = 1'b1;
                re_c   = is_rd;
                we_c   = ~is_rd;
                // MemReady wins over a timeout landing on the same cycle
                if (bus.MemReady || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read wins over a simultaneous write request
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            is_rd   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= bus.SysBusIn;
                        is_rd  <= bus.ReqRead;
                    end
                end
                ADDR: begin
                    if (!is_rd) begin
                        wdata_q <= bus.SysBusIn;
                    end
                end
                ACCESS: begin
                    if (bus.MemReady && is_rd) begin
                        rdata_q <= bus.MemRData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEMIF_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign timeout = (state == ACCESS) && !bus.MemReady && (wait_cnt == CNT_LAST);

    // Error persists from DONE until the next accepted request
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                err_q <= 1'b0;
            end
            if (state == ADDR) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !bus.MemReady) begin
                wait_cnt <= wait_cnt + CW'(1);
                if (timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Error = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign bus.Error          = 1'b0;
`endif

    assign bus.DataIn   = rdata_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemWData = wdata_q;
    assign bus.Busy     = busy_c;
    assign bus.Done     = done_c;
    assign bus.MemRe    = re_c;
    assign bus.MemWe    = we_c;

endmodule

// File: tb/tb_sysbus_mem_if.sv
// Directed bench for sysbus_mem_if; timeout scenario depends on MEMIF_TIMEOUT_EN.
module tb_sysbus_mem_if;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   re_cnt = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;

    sysbus_mem_if_if bus();

    sysbus_mem_if #(.TIMEOUT_CYCLES(15)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (bus.MemRe === 1'b1) re_cnt++;
        if (bus.MemWe === 1'b1) we_cnt++;
        if (bus.Done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_counts();
        re_cnt = 0;
        we_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic test_reset();
        bus.ReqRead  = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.SysBusIn = 16'h0;
        bus.MemRData = 16'h0;
        bus.MemReady = 1'b0;
        nReset = 1'b0;
        tick();
        tick();
        tests++;
        if ({bus.Busy, bus.Done, bus.MemRe, bus.MemWe, bus.Error} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, want 00000", {bus.Busy, bus.Done, bus.MemRe, bus.MemWe, bus.Error});
        end
        tests++;
        if ({bus.DataIn, bus.MemAddr, bus.MemWData} !== 48'h0) begin
            fails++;
            $display("FAIL reset_regs: got %h, want 0", {bus.DataIn, bus.MemAddr, bus.MemWData});
        end
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_read_zero_wait();
        clear_counts();
        bus.SysBusIn = 16'h0040;
        bus.ReqRead  = 1'b1;
        tick();
        bus.ReqRead  = 1'b0;
        bus.SysBusIn = 16'hFFFF;
        tests++;
        if (bus.MemAddr !== 16'h0040 || bus.Busy !== 1'b1 || bus.MemRe !== 1'b0) begin
            fails++;
            $display("FAIL rd0_addr: got addr=%h busy=%b re=%b, want 0040 1 0", bus.MemAddr, bus.Busy, bus.MemRe);
        end
        tick();
        tests++;
        if (bus.MemRe !== 1'b1 || bus.MemWe !== 1'b0 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL rd0_access: got re=%b we=%b done=%b, want 1 0 0", bus.MemRe, bus.MemWe, bus.Done);
        end
        bus.MemReady = 1'b1;
        bus.MemRData = 16'hBEEF;
        tick();
        bus.MemReady = 1'b0;
        bus.MemRData = 16'h0;
        tests++;
        if (bus.Done !== 1'b1 || bus.DataIn !== 16'hBEEF || bus.Error !== 1'b0) begin
            fails++;
            $display("FAIL rd0_done: got done=%b data=%h err=%b, want 1 beef 0", bus.Done, bus.DataIn, bus.Error);
        end
        tick();
        tests++;
        if (re_cnt !== 1 || done_cnt !== 1 || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL rd0_counts: got re=%0d done=%0d busy=%b, want 1 1 0", re_cnt, done_cnt, bus.Busy);
        end
    endtask

    task automatic test_write_wait3();
        clear_counts();
        bus.SysBusIn = 16'h0100;
        bus.ReqWrite = 1'b1;
        tick();
        bus.ReqWrite = 1'b0;
        bus.SysBusIn = 16'h1234;
        tick();
        bus.SysBusIn = 16'hABCD;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.MemWe !== 1'b1 || bus.MemRe !== 1'b0 || bus.MemWData !== 16'h1234 || bus.MemAddr !== 16'h0100) begin
                fails++;
                $display("FAIL wr3_access%0d: got we=%b re=%b wd=%h a=%h, want 1 0 1234 0100", i, bus.MemWe, bus.MemRe, bus.MemWData, bus.MemAddr);
            end
            if (i == 3) bus.MemReady = 1'b1;
            tick();
        end
        bus.MemReady = 1'b0;
        tests++;
        if (bus.Done !== 1'b1 || bus.DataIn !== 16'hBEEF || we_cnt !== 4) begin
            fails++;
            $display("FAIL wr3_done: got done=%b data=%h we=%0d, want 1 beef 4", bus.Done, bus.DataIn, we_cnt);
        end
        tick();
    endtask

`ifdef MEMIF_TIMEOUT_EN
    task automatic test_timeout();
        clear_counts();
        bus.SysBusIn = 16'h0200;
        bus.MemRData = 16'h7777;
        bus.ReqRead  = 1'b1;
        tick();
        bus.ReqRead = 1'b0;
        for (int i = 0; i < 40 && bus.Done !== 1'b1; i++) tick();
        tests++;
        if (bus.Done !== 1'b1 || re_cnt !== 15 || bus.Error !== 1'b1 || bus.DataIn !== 16'hBEEF) begin
            fails++;
            $display("FAIL timeout_done: got done=%b re=%0d err=%b data=%h, want 1 15 1 beef", bus.Done, re_cnt, bus.Error, bus.DataIn);
        end
        tick();
        tick();
        tests++;
        if (bus.Error !== 1'b1) begin
            fails++;
            $display("FAIL timeout_hold: got err=%b, want 1", bus.Error);
        end
        bus.MemReady = 1'b1;
        bus.MemRData = 16'h2222;
        bus.SysBusIn = 16'h0210;
        bus.ReqRead  = 1'b1;
        tick();
        bus.ReqRead = 1'b0;
        tests++;
        if (bus.Error !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: got err=%b, want 0", bus.Error);
        end
        tick();
        tick();
        bus.MemReady = 1'b0;
        tests++;
        if (bus.Done !== 1'b1 || bus.DataIn !== 16'h2222) begin
            fails++;
            $display("FAIL timeout_next: got done=%b data=%h, want 1 2222", bus.Done, bus.DataIn);
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        clear_counts();
        bus.SysBusIn = 16'h0200;
        bus.ReqRead  = 1'b1;
        tick();
        bus.ReqRead = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) tick();
        tests++;
        if (bus.MemRe !== 1'b1 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL nto_wait: got re=%b done=%b, want 1 0", bus.MemRe, bus.Done);
        end
        bus.MemReady = 1'b1;
        bus.MemRData = 16'h2222;
        tick();
        bus.MemReady = 1'b0;
        tests++;
        if (bus.Done !== 1'b1 || re_cnt !== 41 || bus.Error !== 1'b0 || bus.DataIn !== 16'h2222) begin
            fails++;
            $display("FAIL nto_done: got done=%b re=%0d err=%b data=%h, want 1 41 0 2222", bus.Done, re_cnt, bus.Error, bus.DataIn);
        end
        tick();
    endtask
`endif

    task automatic test_simultaneous_and_busy();
        clear_counts();
        bus.SysBusIn = 16'h0300;
        bus.ReqRead  = 1'b1;
        bus.ReqWrite = 1'b1;
        tick();
        bus.ReqRead  = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.SysBusIn = 16'h9999;
        tick();
        tests++;
        if (bus.MemRe !== 1'b1 || bus.MemWe !== 1'b0 || bus.MemAddr !== 16'h0300) begin
            fails++;
            $display("FAIL both_dir: got re=%b we=%b a=%h, want 1 0 0300", bus.MemRe, bus.MemWe, bus.MemAddr);
        end
        bus.ReqWrite = 1'b1;
        tick();
        bus.ReqWrite = 1'b0;
        bus.MemReady = 1'b1;
        bus.MemRData = 16'hC0DE;
        tick();
        bus.MemReady = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (we_cnt !== 0 || done_cnt !== 1 || bus.DataIn !== 16'hC0DE || bus.Busy !== 1'b0) begin
            fails++;
            $display("FAIL both_result: got we=%0d done=%0d data=%h busy=%b, want 0 1 c0de 0", we_cnt, done_cnt, bus.DataIn, bus.Busy);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        bus.SysBusIn = 16'h0400;
        bus.ReqRead  = 1'b1;
        tick();
        bus.ReqRead = 1'b0;
        tick();
        tick();
        nReset = 1'b0;
        tick();
        tests++;
        if (bus.MemRe !== 1'b0 || bus.Busy !== 1'b0 || bus.DataIn !== 16'h0 || bus.MemAddr !== 16'h0) begin
            fails++;
            $display("FAIL rstmid_state: got re=%b busy=%b data=%h a=%h, want 0 0 0000 0000", bus.MemRe, bus.Busy, bus.DataIn, bus.MemAddr);
        end
        nReset = 1'b1;
        tick();
        tick();
        tests++;
        if (done_cnt !== 0) begin
            fails++;
            $display("FAIL rstmid_nodone: got done=%0d, want 0", done_cnt);
        end
        bus.SysBusIn = 16'h0500;
        bus.ReqRead  = 1'b1;
        tick();
        bus.ReqRead = 1'b0;
        tick();
        bus.MemReady = 1'b1;
        bus.MemRData = 16'h1111;
        tick();
        bus.MemReady = 1'b0;
        tests++;
        if (bus.Done !== 1'b1 || bus.DataIn !== 16'h1111 || bus.MemAddr !== 16'h0500) begin
            fails++;
            $display("FAIL rstmid_fresh: got done=%b data=%h a=%h, want 1 1111 0500", bus.Done, bus.DataIn, bus.MemAddr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait3();
`ifdef MEMIF_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_simultaneous_and_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
